// File: rtl/flash_reader_pkg.sv
// Shared definitions for the SPI flash readers: command opcodes and FSM state encoding.
package flash_reader_pkg;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam int         CMD_BITS       = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_STALL,
    ST_GAP
  } fr_state_e;

endpackage

// File: rtl/flash_reader_spi_clk_gen.sv
// SCK generator: CLK_DIV cycles per half-period, one-cycle rise/fall strobes, freezable via en_i.
module spi_clk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          wrap;

  // Strobes flag the clock edge at which SCK toggles.
  assign wrap   = en_i && (cnt_q == TERM);
  assign rise_o = wrap && !sck_q;
  assign fall_o = wrap && sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (clr_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (en_i) begin
      if (wrap) begin
        cnt_d = '0;
        sck_d = !sck_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/flash_reader.sv
// SPI mode-0 flash READ (0x03) master streaming bytes out over valid/ready with a one-byte skid.
module flash_reader
  import flash_reader_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int LEN_W   = 16,
  parameter int CS_HIGH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             FLASH_CSb,
  output logic             FLASH_SCK,
  output logic             FLASH_MOSI,
  input  logic             FLASH_MISO
);

  localparam int GW = (CS_HIGH > 1) ? $clog2(CS_HIGH + 1) : 1;

  fr_state_e        state_q;
  logic             busy_q, done_q, csb_q;
  logic [31:0]      sr_q;
  logic [4:0]       bit_q;
  logic [6:0]       rx_q;
  logic [LEN_W-1:0] left_q;
  logic [7:0]       dout_q, skid_q;
  logic             dv_q, skid_vld_q;
  logic [GW-1:0]    gap_q;

  logic       sck, rise, fall, gen_en, gen_clr;
  logic       out_free, gap_done;
  logic [7:0] byte_d;

  assign gen_en   = (state_q == ST_CMD) || (state_q == ST_DATA);
  assign gen_clr  = (state_q == ST_IDLE);
  assign out_free = !dv_q || data_ready;
  assign byte_d   = {rx_q, FLASH_MISO};
  assign gap_done = (int'(gap_q) + 1) >= CS_HIGH;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i  (CLK),
    .rst_i  (RST),
    .en_i   (gen_en),
    .clr_i  (gen_clr),
    .sck_o  (sck),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      csb_q      <= 1'b1;
      sr_q       <= '0;
      dv_q       <= 1'b0;
      dout_q     <= '0;
      skid_vld_q <= 1'b0;
      gap_q      <= '0;
    end else begin
      done_q <= 1'b0;

      // Output register: consume, then refill from the skid byte if one is waiting.
      if (dv_q && data_ready) dv_q <= 1'b0;
      if (skid_vld_q && out_free) begin
        dout_q     <= skid_q;
        dv_q       <= 1'b1;
        skid_vld_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          gap_q <= '0;
          if (start) begin
            if (len != '0) begin
              busy_q  <= 1'b1;
              csb_q   <= 1'b0;
              sr_q    <= {FLASH_CMD_READ, addr};
              left_q  <= len;
              bit_q   <= '0;
              state_q <= ST_CMD;
            end else begin
              done_q <= 1'b1;
            end
          end
        end

        ST_CMD: begin
          if (fall) begin
            sr_q  <= {sr_q[30:0], 1'b0};
            bit_q <= bit_q + 5'd1;
            if (bit_q == 5'(CMD_BITS - 1)) begin
              bit_q   <= '0;
              state_q <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (rise) begin
            rx_q  <= byte_d[6:0];
            bit_q <= bit_q + 5'd1;
            if (bit_q == 5'd7) begin
              bit_q  <= '0;
              left_q <= left_q - 1'b1;
              if (out_free) begin
                dout_q <= byte_d;
                dv_q   <= 1'b1;
              end else begin
                skid_q     <= byte_d;
                skid_vld_q <= 1'b1;
              end
            end
          end else if (fall) begin
            // Freeze only with SCK low; a drained skid lets the next byte proceed.
            if (left_q == '0) begin
              csb_q   <= 1'b1;
              state_q <= ST_GAP;
            end else if (skid_vld_q && !out_free) begin
              state_q <= ST_STALL;
            end
          end
        end

        ST_STALL: begin
          if (out_free) state_q <= ST_DATA;
        end

        ST_GAP: begin
          if (gap_done && !dv_q && !skid_vld_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!gap_done) begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign FLASH_CSb  = csb_q;
  assign FLASH_SCK  = sck;
  assign FLASH_MOSI = sr_q[31];

endmodule

// File: tb/tb_flash_reader.sv
// Bench for flash_reader: two DUTs (CLK_DIV 1 and 3), behavioural SPI flash and byte-stream reference.
module tb_flash_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  start = '0;
  logic [1:0]  ready = '0;
  logic [1:0]  miso  = '0;
  logic [23:0] addr [2];
  logic [15:0] len  [2];
  wire  [1:0]  busy, done, dv, csb, sck, mosi;
  wire  [7:0]  dout [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    flash_reader #(.CLK_DIV(g == 0 ? 1 : 3), .LEN_W(16), .CS_HIGH(4)) u_dut (
      .CLK        (clk),
      .RST        (rst),
      .start      (start[g]),
      .addr       (addr[g]),
      .len        (len[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .data_out   (dout[g]),
      .data_valid (dv[g]),
      .data_ready (ready[g]),
      .FLASH_CSb  (csb[g]),
      .FLASH_SCK  (sck[g]),
      .FLASH_MOSI (mosi[g]),
      .FLASH_MISO (miso[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Flash contents: a fixed pattern with the two bytes the basic read expects.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a == 24'h010000) return 8'hA5;
    if (a == 24'h010001) return 8'h3C;
    return 8'(a * 37 + (a >> 8) * 11 + 24'h5A);
  endfunction

  // Flash model and bus monitors, all sampled on the falling CLK edge.
  int          cur_rise [2], rxn [2], done_tot [2], sck_chg [2], mosi_err [2];
  int          done_busy_err [2], phase_err [2], ph_cnt [2], hi_cnt [2], csb_falls [2];
  int          min_gap [2] = '{1000, 1000};
  bit          seen [2];
  logic [31:0] cur_cmd [2];
  logic [7:0]  rxbuf [2][256];
  logic [1:0]  sck_prev = 2'b00, csb_prev = 2'b11, mosi_prev = 2'b00;
  int          m_idx;
  logic [7:0]  m_b;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (csb[d] === 1'b0 && csb_prev[d] === 1'b1) begin
        cur_rise[d] = 0;
        cur_cmd[d]  = '0;
        ph_cnt[d]   = 0;
        if (seen[d] && hi_cnt[d] < min_gap[d]) min_gap[d] = hi_cnt[d];
        seen[d] = 1'b1;
        csb_falls[d]++;
      end
      if (csb[d] === 1'b1) hi_cnt[d]++;
      else hi_cnt[d] = 0;

      if (sck[d] !== sck_prev[d]) begin
        sck_chg[d]++;
        if (ph_cnt[d] != (d == 0 ? 1 : 3)) phase_err[d]++;
        ph_cnt[d] = 1;
      end else begin
        ph_cnt[d]++;
      end

      if (csb[d] === 1'b0 && sck[d] === 1'b1 && sck_prev[d] === 1'b0) begin
        if (mosi[d] !== mosi_prev[d]) mosi_err[d]++;
        if (cur_rise[d] < 32) cur_cmd[d] = {cur_cmd[d][30:0], mosi[d]};
        cur_rise[d]++;
      end
      if (csb[d] === 1'b0 && sck[d] === 1'b0 && sck_prev[d] === 1'b1 && cur_rise[d] >= 32) begin
        m_idx   = cur_rise[d] - 32;
        m_b     = mem_byte(cur_cmd[d][23:0] + 24'(m_idx / 8));
        miso[d] = m_b[7 - (m_idx % 8)];
      end

      if (dv[d] === 1'b1 && ready[d]) begin
        rxbuf[d][rxn[d] % 256] = dout[d];
        rxn[d]++;
      end
      if (done[d] === 1'b1) begin
        done_tot[d]++;
        if (busy[d] !== 1'b0) done_busy_err[d]++;
      end
      sck_prev[d]  = sck[d];
      csb_prev[d]  = csb[d];
      mosi_prev[d] = mosi[d];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready held high; 1: random ready; 2: 100-cycle backpressure after first byte;
  // 3: a second start is issued mid-read and must be ignored.
  task automatic run_tx(input int d, input logic [23:0] a, input int n, input int mode);
    int rx0, dn0, ph0, mo0, db0, cyc, bp, sc0, sc1, csb_bad;
    rx0 = rxn[d]; dn0 = done_tot[d]; ph0 = phase_err[d];
    mo0 = mosi_err[d]; db0 = done_busy_err[d];
    bp = -1; sc0 = 0; sc1 = -1; csb_bad = 0; cyc = 0;
    start[d] = 1'b1; addr[d] = a; len[d] = 16'(n);
    ready[d] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    start[d] = 1'b0;
    chk("busy_after_start", busy[d], 1);
    while (done_tot[d] == dn0 && cyc < 20000) begin
      if (mode == 1) ready[d] = 1'($urandom_range(0, 1));
      if (mode == 2) begin
        if (bp < 0 && rxn[d] > rx0) bp = 0;
        if (bp >= 0 && bp < 100) begin
          ready[d] = 1'b0;
          if (bp == 50) sc0 = sck_chg[d];
          if (bp >= 50 && csb[d] !== 1'b0) csb_bad++;
          if (bp == 99) sc1 = sck_chg[d];
          bp++;
        end else begin
          ready[d] = 1'b1;
        end
      end
      if (mode == 3) begin
        start[d] = (cyc == 20);
        if (cyc == 20) begin addr[d] = 24'h000000; len[d] = 16'd5; end
      end
      tick();
      cyc++;
    end
    start[d] = 1'b0;
    ready[d] = 1'b1;
    chk("done_seen", done_tot[d] - dn0, 1);
    chk("busy_low_at_done", busy[d], 0);
    chk("csb_high_after", csb[d], 1);
    chk("dv_clear_after", dv[d], 0);
    repeat (3) tick();
    chk("done_single_pulse", done_tot[d] - dn0, 1);
    chk("done_with_busy", done_busy_err[d] - db0, 0);
    chk("cmd_word", cur_cmd[d], {8'h03, a});
    chk("sck_rises", cur_rise[d], 32 + 8 * n);
    chk("mosi_stable", mosi_err[d] - mo0, 0);
    chk("byte_count", rxn[d] - rx0, n);
    for (int i = 0; i < n; i++)
      chk($sformatf("byte%0d", i), rxbuf[d][(rx0 + i) % 256], mem_byte(a + 24'(i)));
    if (mode == 0) chk("sck_phase_len", phase_err[d] - ph0, 0);
    if (mode == 2) begin
      chk("stall_sck_frozen", sc1 - sc0, 0);
      chk("stall_csb_low", csb_bad, 0);
    end
  endtask

  initial begin
    int dn0, sc0, cf0, d, n;
    addr[0] = '0; addr[1] = '0; len[0] = '0; len[1] = '0;
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_csb", csb[k], 1);
      chk("rst_sck", sck[k], 0);
      chk("rst_mosi", mosi[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_done", done[k], 0);
      chk("rst_dv", dv[k], 0);
      chk("rst_dout", dout[k], 0);
    end
    ready = 2'b11;
    tick();

    run_tx(0, 24'h010000, 2, 0);
    chk("basic_b0", rxbuf[0][0], 8'hA5);
    chk("basic_b1", rxbuf[0][1], 8'h3C);

    run_tx(0, 24'h020000, 4, 2);

    // Zero-length request completes without touching the bus.
    dn0 = done_tot[0]; sc0 = sck_chg[0]; cf0 = csb_falls[0];
    start[0] = 1'b1; addr[0] = 24'h123456; len[0] = 16'd0;
    tick();
    start[0] = 1'b0;
    chk("len0_done", done[0], 1);
    chk("len0_busy", busy[0], 0);
    tick();
    chk("len0_done_drop", done[0], 0);
    repeat (3) tick();
    chk("len0_done_count", done_tot[0] - dn0, 1);
    chk("len0_no_cs", csb_falls[0] - cf0, 0);
    chk("len0_no_sck", sck_chg[0] - sc0, 0);

    // Reset in the middle of the command phase.
    dn0 = done_tot[0];
    start[0] = 1'b1; addr[0] = 24'h030000; len[0] = 16'd3;
    tick();
    start[0] = 1'b0;
    for (int c = 0; c < 500 && cur_rise[0] < 12; c++) tick();
    chk("reach_cmd_bit12", cur_rise[0] >= 12, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_csb", csb[0], 1);
    chk("abort_sck", sck[0], 0);
    chk("abort_dv", dv[0], 0);
    chk("abort_busy", busy[0], 0);
    repeat (10) tick();
    chk("abort_no_done", done_tot[0] - dn0, 0);
    run_tx(0, 24'h010000, 2, 0);

    run_tx(0, 24'h000100, 3, 3);
    run_tx(0, 24'h000200, 1, 0);

    run_tx(1, 24'h010000, 1, 0);

    for (int t = 0; t < 6; t++) begin
      d = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 5));
      run_tx(d, 24'($urandom), n, 1);
    end

    chk("cs_high_gap_0", min_gap[0] >= 4, 1);
    chk("cs_high_gap_1", min_gap[1] >= 4, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
